store_narrow_unit: RTL and testbench
====================================

# store_narrow_unit

Multi-cycle sub-word store engine for the processor's data-memory path: narrows a 32-bit register value to byte, halfword or word and writes it into word-organised data memory. Byte and halfword stores use read-modify-write. It also flags values that do not survive the round trip narrow-then-sign-extend. This is the write-side counterpart of the immediate/load sign-extension logic. The block sits between the execute stage and the data-memory port, with a start/done handshake toward the core.

## Interface
- No parameters; data width fixed at 32, address width fixed at 32.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- addr  in  32  byte address of the store
- wdata  in  32  register value; low 8/16/32 bits are stored
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on misalignment or illegal size; no memory access
- trunc_ovf  out  1  valid with done: value not representable as signed sub-word
- mem_addr  out  32  word address {addr_q[31:2],2'b00}
- mem_re  out  1  read request, held until mem_ready
- mem_rdata  in  32  read data, valid when mem_ready and mem_re
- mem_we  out  1  write request, held until mem_ready
- mem_wdata  out  32  merged write word
- mem_ready  in  1  memory acknowledge; any latency ≥0 cycles after request

## Operation
- FSM states: IDLE, READ, WRITE, FIN.
- IDLE with start=1 latches size, addr and wdata. Next state:
  - size=11, or halfword with addr[0]=1, or word with addr[1:0]≠00: err=1 for the next cycle and stay IDLE.
  - word: WRITE.
  - byte/half: READ.
- READ: mem_re=1. On mem_ready, capture mem_rdata into old_q and go to WRITE.
- WRITE: mem_we=1. mem_wdata = old_q with the target lane replaced; lanes are little-endian.
  - byte lane: addr[1:0]×8.
  - half lane: addr[1]×16.
  - word: mem_wdata = wdata_q.
- WRITE exit: on mem_ready go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- trunc_ovf:
  - byte: wdata_q[31:7] not all equal.
  - half: wdata_q[31:15] not all equal.
  - word: always 0.
  - Registered at latch; held stable until the next accepted start.
- start while busy is ignored (not queued).
- mem_re and mem_we are never high together. Both are 0 in IDLE and FIN.
- Reset values: busy=0, done=0, err=0, trunc_ovf=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE.

## Timing
- Outputs are registered or decoded from state only; no combinational path from start to mem_*.
- Latency from start edge (cycle 0) to done, with mem_ready returned k cycles after request (k=0 means same cycle):
  - byte/half: done in cycle 3+k_read+k_write.
  - word: done in cycle 2+k_write.
- err is high in cycle 1 and busy stays 0.
- mem_addr and mem_wdata are stable for the whole time mem_re or mem_we is high.
- rst mid-operation: at the next edge, return to IDLE and drop mem_re/mem_we. No done is emitted. The partially completed store is abandoned: no write, or the write aborts.
- A new start is accepted in the cycle after FIN (IDLE); back-to-back stores have a 1-cycle gap.

## Test plan
- Byte store, addr=0x1003, wdata=0x000000AB, mem_rdata=0x11223344, k=0 → mem_wdata=0xAB223344 at word 0x1000, done in cycle 3, trunc_ovf=1 (0xAB has bit7 set, upper bits 0).
- Half store, addr=0x2002, wdata=0xFFFF8001, mem_rdata=0xDEADBEEF, k_read=2, k_write=1 → mem_wdata=0x8001BEEF, done in cycle 6, trunc_ovf=0.
- Word store, addr=0x3000, wdata=0x12345678, k=0 → no mem_re, mem_we with 0x12345678, done in cycle 2.
- Misaligned half at addr=0x4001, and size=11 → err pulse in cycle 1, busy=0, no mem_re/mem_we, done never asserts.
- rst asserted during READ with mem_ready held low → next cycle IDLE, busy=0, mem_re=0, no done. A following byte store completes normally.
- start pulsed during WRITE → ignored; exactly one done, and the latched operands are unchanged.

Source files
------------

// File: rtl/store_narrow_unit.sv
// Sub-word store engine: narrows a register value to byte/half/word and
// writes it to word-organised memory, using read-modify-write for sub-words.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, size,       request pulse (taken only when idle), store size
//   addr, wdata        (00 byte, 01 half, 10 word, 11 illegal), byte address
//                      and register value
//   busy, done, err    not-idle flag, completion pulse, reject pulse
//   trunc_ovf          value does not survive narrow-then-sign-extend
//   mem_addr           word address of the store
//   mem_re, mem_rdata  read request (held until mem_ready), read data
//   mem_we, mem_wdata  write request (held until mem_ready), merged word
//   mem_ready          memory acknowledge, zero or more cycles after request
module store_narrow_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        trunc_ovf,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;
  logic        err_q;
  logic        ovf_q;

  logic        accept;
  logic        bad;
  logic        ovf_in;
  logic [31:0] merged;

  assign accept = (state_q == IDLE) && start;

  // Reject illegal size and any access that straddles its natural lane.
  always_comb begin
    bad = 1'b0;
    unique case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr[0];
      SZ_W:    bad = |addr[1:0];
      default: bad = 1'b1;
    endcase
  end

  // A value survives the round trip only if every bit above the
  // sub-word sign bit replicates that sign bit.
  always_comb begin
    ovf_in = 1'b0;
    unique case (size)
      SZ_B: ovf_in = !((&wdata[31:7]) || !(|wdata[31:7]));
      SZ_H: ovf_in = !((&wdata[31:15]) || !(|wdata[31:15]));
      default: ovf_in = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && !bad) begin
          state_d = (size == SZ_W) ? WRITE : READ;
        end
      end
      READ: begin
        if (mem_ready) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (mem_ready) begin
          state_d = FIN;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && bad;
      if (accept) begin
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
        ovf_q   <= ovf_in;
      end
      if ((state_q == READ) && mem_ready) begin
        old_q <= mem_rdata;
      end
    end
  end

  // Little-endian lane replacement; only registered operands feed it, so
  // the write word is stable for the whole request.
  always_comb begin
    merged = old_q;
    unique case (size_q)
      SZ_B: begin
        unique case (addr_q[1:0])
          2'd0: merged[7:0]   = wdata_q[7:0];
          2'd1: merged[15:8]  = wdata_q[7:0];
          2'd2: merged[23:16] = wdata_q[7:0];
          2'd3: merged[31:24] = wdata_q[7:0];
          default: merged = old_q;
        endcase
      end
      SZ_H: begin
        if (addr_q[1]) begin
          merged[31:16] = wdata_q[15:0];
        end else begin
          merged[15:0] = wdata_q[15:0];
        end
      end
      SZ_W: merged = wdata_q;
      default: merged = old_q;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign mem_re    = (state_q == READ);
  assign mem_we    = (state_q == WRITE);
  assign err       = err_q;
  assign trunc_ovf = ovf_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = merged;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Randomised bench for store_narrow_unit with a behavioural memory
// responder and a lane/overflow/latency reference model.
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic        trunc_ovf;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata = '0;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;

  store_narrow_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .trunc_ovf (trunc_ovf),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver-owned memory image and responder controls.
  logic [31:0] mem [logic [29:0]];
  int k_rd = 0;
  int k_wr = 0;
  bit stall = 0;

  function automatic logic [31:0] rd(input logic [29:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  int pcyc = 0;
  always @(posedge clk) pcyc++;

  // Monitor-owned observations.
  int wcnt = 0;
  int we_cnt = 0, re_cnt = 0, done_cnt = 0, err_cnt = 0;
  int busy_cnt = 0, viol = 0;
  int done_at = 0, err_at = 0;
  logic [31:0] w_addr = '0, w_data = '0;
  logic done_trunc = 1'b0;
  logic prev_re = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  always @(negedge clk) begin
    if (mem_ready) begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
    if (!(mem_re || mem_we)) begin
      wcnt = 0;
    end else if (!stall) begin
      if (wcnt >= (mem_re ? k_rd : k_wr)) mem_ready = 1'b1;
      else wcnt++;
    end
    mem_rdata = mem_re ? rd(mem_addr[31:2]) : $urandom;
    if (mem_re && mem_ready) re_cnt++;
    if (mem_we && mem_ready) begin
      we_cnt++;
      w_addr = mem_addr;
      w_data = mem_wdata;
    end
    if (done) begin
      done_cnt++;
      done_at = pcyc;
      done_trunc = trunc_ovf;
    end
    if (err) begin
      err_cnt++;
      err_at = pcyc;
    end
    if (busy) busy_cnt++;
    if (mem_re && mem_we) viol++;
    if ((mem_re || mem_we) && done) viol++;
    if ((mem_re && prev_re) || (mem_we && prev_we)) begin
      if (mem_addr != prev_addr || mem_wdata != prev_wdata) viol++;
    end
    prev_re = mem_re;
    prev_we = mem_we;
    prev_addr = mem_addr;
    prev_wdata = mem_wdata;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] ad);
    return (sz == 2'd3) || (sz == 2'd1 && ad % 2 != 0) ||
           (sz == 2'd2 && ad % 4 != 0);
  endfunction

  function automatic int latency(input logic [1:0] sz, input int kr,
                                 input int kw);
    return (sz == 2'd2) ? 2 + kw : 3 + kr + kw;
  endfunction

  task automatic run_op(input logic [1:0] sz, input logic [31:0] ad,
                        input logic [31:0] wd, input logic [31:0] ow,
                        input int kr, input int kw, input int poke);
    int P, b_we, b_re, b_done, b_err, b_busy, b_viol, sh, sv;
    bit ill, fin, ovf;
    logic [31:0] mask, ex;
    ill = is_bad(sz, ad);
    ex = ow;
    ovf = 0;
    sv = wd;
    if (sz == 2'd0) begin
      sh = 8 * (ad % 4);
      mask = 32'hFF << sh;
      ex = (ow & ~mask) | ((wd & 32'hFF) << sh);
      ovf = (sv < -128) || (sv > 127);
    end else if (sz == 2'd1) begin
      sh = 16 * ((ad / 2) % 2);
      mask = 32'hFFFF << sh;
      ex = (ow & ~mask) | ((wd & 32'hFFFF) << sh);
      ovf = (sv < -32768) || (sv > 32767);
    end else if (sz == 2'd2) begin
      ex = wd;
    end
    tick();
    mem[ad[31:2]] = ow;
    k_rd = kr;
    k_wr = kw;
    b_we = we_cnt; b_re = re_cnt; b_done = done_cnt;
    b_err = err_cnt; b_busy = busy_cnt; b_viol = viol;
    P = pcyc;
    start = 1'b1;
    size = sz;
    addr = ad;
    wdata = wd;
    fin = 0;
    for (int i = 1; i <= 40 && !fin; i++) begin
      tick();
      start = (i == poke);
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
      wdata = $urandom;
      if (done_cnt != b_done || err_cnt != b_err) fin = 1;
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("finished", 32'(fin), 32'd1);
    if (ill) begin
      check("err_cycle", err_at - P, 1);
      check("err_busy", busy_cnt - b_busy, 0);
      check("err_memacc", (we_cnt - b_we) + (re_cnt - b_re), 0);
      check("err_done", done_cnt - b_done, 0);
    end else begin
      check("done_cycle", done_at - P, latency(sz, kr, kw));
      check("done_count", done_cnt - b_done, 1);
      check("err_count", err_cnt - b_err, 0);
      check("write_count", we_cnt - b_we, 1);
      check("read_count", re_cnt - b_re, (sz == 2'd2) ? 0 : 1);
      check("write_addr", w_addr, {ad[31:2], 2'b00});
      check("write_data", w_data, ex);
      check("trunc_ovf", 32'(done_trunc), 32'(ovf));
      check("protocol", viol - b_viol, 0);
    end
  endtask

  initial begin
    int b_done, b_we, P;
    logic [1:0] sz;
    logic [31:0] ad, wd, tmp;
    int kr, kw, pk;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_trunc", 32'(trunc_ovf), 0);
    check("rst_re", 32'(mem_re), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_mwdata", mem_wdata, 0);
    rst = 1'b0;
    tick();

    run_op(2'd0, 32'h0000_1003, 32'h0000_00AB, 32'h1122_3344, 0, 0, 0);
    run_op(2'd1, 32'h0000_2002, 32'hFFFF_8001, 32'hDEAD_BEEF, 2, 1, 0);
    run_op(2'd2, 32'h0000_3000, 32'h1234_5678, 32'hCAFE_F00D, 0, 0, 0);
    run_op(2'd1, 32'h0000_4001, 32'h0000_1234, 32'h0, 0, 0, 0);
    run_op(2'd3, 32'h0000_4000, 32'h0000_1234, 32'h0, 0, 0, 0);
    run_op(2'd2, 32'h0000_4002, 32'h0000_1234, 32'h0, 0, 0, 0);
    run_op(2'd0, 32'h0000_5000, 32'hFFFF_FF80, 32'h0, 0, 0, 0);
    run_op(2'd1, 32'h0000_5000, 32'h0000_8000, 32'hFFFF_FFFF, 1, 0, 0);
    // start during WRITE (cycle 3 of a byte store with a slow write)
    run_op(2'd0, 32'h0000_6001, 32'h0000_007F, 32'h5555_AAAA, 0, 3, 3);

    // reset while READ is stalled
    tick();
    stall = 1;
    mem[30'h180] = 32'h0;
    b_done = done_cnt;
    b_we = we_cnt;
    P = pcyc;
    start = 1'b1; size = 2'd0; addr = 32'h0000_0600; wdata = 32'h11;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 0);
    check("midrst_re", 32'(mem_re), 0);
    rst = 1'b0;
    stall = 0;
    for (int i = 0; i < 5; i++) tick();
    check("midrst_done", done_cnt - b_done, 0);
    check("midrst_write", we_cnt - b_we, 0);
    check("midrst_elapsed", 32'(pcyc - P > 0), 1);
    run_op(2'd0, 32'h0000_0602, 32'h0000_0042, 32'h0102_0304, 1, 1, 0);

    for (int n = 0; n < 40; n++) begin
      sz = 2'($urandom_range(0, 3));
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) ad[0] = 1'b0;
        if (sz == 2'd2) ad[1:0] = 2'b00;
      end
      tmp = $urandom;
      case ($urandom_range(0, 2))
        0: wd = tmp;
        1: wd = {{24{tmp[7]}}, tmp[7:0]};
        default: wd = {{16{tmp[15]}}, tmp[15:0]};
      endcase
      kr = $urandom_range(0, 3);
      kw = $urandom_range(0, 3);
      pk = is_bad(sz, ad) ? 0 : $urandom_range(0, latency(sz, kr, kw));
      run_op(sz, ad, wd, $urandom, kr, kw, pk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
